// File: rtl/dec38_pkg.sv
// Shared constants and state encoding for the decoder_38 round-robin arbiter.
package dec38_pkg;

  localparam int N_REQ = 8;

  localparam logic [2:0] DEC_EN_ON  = 3'b100;
  localparam logic [2:0] DEC_EN_OFF = 3'b000;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec38_rr_arbiter_rr_pick8.sv
// Rotating priority search: returns the first set request at or after start (mod 8).
module rr_pick8
  import dec38_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       start,
  output logic             any,
  output logic [2:0]       idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [2:0]         off;

  // Doubling the vector turns the circular rotation into a plain part-select.
  assign dbl = {req, req};
  assign rot = dbl[start +: N_REQ];

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
  end

  assign any = |req;
  assign idx = start + off;

endmodule

// File: rtl/decoder_38.sv
// 3-to-8 decoder with a 3-bit enable group; outputs are active only when en_i = 3'b100.
module decoder_38 (
  input  logic [2:0] data_i,
  input  logic [2:0] en_i,
  output logic [7:0] data_o
);

  assign data_o = (en_i == 3'b100) ? (8'b1 << data_i) : 8'h00;

endmodule

// File: rtl/dec38_rr_arbiter.sv
// 8-way round-robin arbiter driving one decoder_38 as a one-hot grant bus.
// Optional GRANT_TIMEOUT_EN forces rotation after HOLD_MAX grant cycles when others wait.
module dec38_rr_arbiter
  import dec38_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [2:0]       dec_data_o,
  output logic [2:0]       dec_en_o,
  output logic             gnt_valid_o,
  output logic [2:0]       gnt_idx_o
);

  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold
      $error("HOLD_MAX must be within 2..256");
    end
  endgenerate

  state_t     state_reg;
  logic [2:0] ptr_reg;
  logic [2:0] gnt_idx_reg;
  logic [2:0] dec_en_reg;
  logic       gnt_valid_reg;

  logic [2:0] search_start;
  logic       pick_any;
  logic [2:0] pick_idx;
  logic       release_now;

  // On entry search from ptr; on release/rotation search just past the holder.
  assign search_start = (state_reg == S_GRANT) ? gnt_idx_reg + 3'd1 : ptr_reg;

  rr_pick8 u_pick (
    .req   (req_i),
    .start (search_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [N_REQ-1:0] holder_mask;
  logic             others_pending;

  assign holder_mask    = N_REQ'(1) << gnt_idx_reg;
  assign others_pending = |(req_i & ~holder_mask);
  assign release_now    = !req_i[gnt_idx_reg] || (cnt_reg == CNT_LAST && others_pending);
`else
  assign release_now    = !req_i[gnt_idx_reg];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      gnt_idx_reg   <= '0;
      dec_en_reg    <= DEC_EN_OFF;
      gnt_valid_reg <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      cnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pick_any) begin
            gnt_idx_reg   <= pick_idx;
            dec_en_reg    <= DEC_EN_ON;
            gnt_valid_reg <= 1'b1;
            state_reg     <= S_GRANT;
`ifdef GRANT_TIMEOUT_EN
            cnt_reg       <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (release_now) begin
            ptr_reg <= gnt_idx_reg + 3'd1;
            if (pick_any) begin
              // Hand over on the same edge so the grant bus has no bubble.
              gnt_idx_reg <= pick_idx;
`ifdef GRANT_TIMEOUT_EN
              cnt_reg     <= '0;
`endif
            end else begin
              // Index is kept; only the enable drops.
              dec_en_reg    <= DEC_EN_OFF;
              gnt_valid_reg <= 1'b0;
              state_reg     <= S_IDLE;
            end
          end
`ifdef GRANT_TIMEOUT_EN
          else if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign dec_data_o  = gnt_idx_reg;
  assign gnt_idx_o   = gnt_idx_reg;
  assign dec_en_o    = dec_en_reg;
  assign gnt_valid_o = gnt_valid_reg;

endmodule

// File: tb/tb_dec38_rr_arbiter.sv
// Directed bench for dec38_rr_arbiter driving decoder_38; decoder data_o is checked as the one-hot grant.
module tb_dec38_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] dec_data;
  logic [2:0] dec_en;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] onehot;

  int n_checks = 0;
  int n_err    = 0;

  dec38_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .dec_data_o  (dec_data),
    .dec_en_o    (dec_en),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  decoder_38 u_dec (
    .data_i (dec_data),
    .en_i   (dec_en),
    .data_o (onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       valid;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs [22];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic valid, input logic [2:0] idx);
    logic [7:0] exp_onehot;
    exp_onehot = valid ? (8'b1 << idx) : 8'h00;
    $display("%s: req=%h valid=%b en=%b idx=%0d data_o=%h", tag, req, gnt_valid, dec_en, gnt_idx, onehot);
    check({tag, " valid"},  {7'b0, gnt_valid}, {7'b0, valid});
    check({tag, " en"},     {5'b0, dec_en},    valid ? 8'h04 : 8'h00);
    check({tag, " idx"},    {5'b0, gnt_idx},   {5'b0, idx});
    check({tag, " data"},   {5'b0, dec_data},  {5'b0, idx});
    check({tag, " onehot"}, onehot,            exp_onehot);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 3'd0};
    vecs[1]  = '{8'h08, 1'b1, 3'd3};
    vecs[2]  = '{8'h08, 1'b1, 3'd3};
    vecs[3]  = '{8'h00, 1'b0, 3'd3};
    vecs[4]  = '{8'h11, 1'b1, 3'd4};
    vecs[5]  = '{8'h01, 1'b1, 3'd0};
    vecs[6]  = '{8'h00, 1'b0, 3'd0};
    vecs[7]  = '{8'h80, 1'b1, 3'd7};
    vecs[8]  = '{8'h00, 1'b0, 3'd7};
    vecs[9]  = '{8'h81, 1'b1, 3'd0};
    vecs[10] = '{8'h80, 1'b1, 3'd7};
    vecs[11] = '{8'h82, 1'b1, 3'd7};
    vecs[12] = '{8'h02, 1'b1, 3'd1};
    vecs[13] = '{8'h00, 1'b0, 3'd1};
    vecs[14] = '{8'h02, 1'b1, 3'd1};
    vecs[15] = '{8'h04, 1'b1, 3'd2};
    vecs[16] = '{8'h00, 1'b0, 3'd2};
    vecs[17] = '{8'h01, 1'b1, 3'd0};
    vecs[18] = '{8'h02, 1'b1, 3'd1};
    vecs[19] = '{8'h03, 1'b1, 3'd1};
    vecs[20] = '{8'h01, 1'b1, 3'd0};
    vecs[21] = '{8'h00, 1'b0, 3'd0};

    rst_n = 1'b0;
    req   = 8'h00;
    #12;
    check_grant("reset", 1'b0, 3'd0);
    rst_n = 1'b1;

    // Single requester, wrap, pointer and no-preempt vectors.
    for (int i = 0; i < 22; i++) begin
      req = vecs[i].req;
      step();
      check_grant($sformatf("vec%0d", i), vecs[i].valid, vecs[i].idx);
    end

    // Fairness: all request, each holder releases after two cycles.
    pulse_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k < 8; k++) begin
      check_grant($sformatf("fair%0d_a", k), 1'b1, 3'(k));
      req = 8'hFF;
      step();
      check_grant($sformatf("fair%0d_b", k), 1'b1, 3'(k));
      req = 8'hFF & ~(8'b1 << k);
      step();
    end
    check_grant("fair_wrap", 1'b1, 3'd0);

    // Hold limit behaviour with two requesters, then a lone requester.
    req = 8'h00;
    pulse_reset();
    req = 8'h03;
    step();
`ifdef GRANT_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      check_grant($sformatf("hold%0d", c), 1'b1, 3'd0);
      step();
    end
    check_grant("rotate", 1'b1, 3'd1);
`else
    for (int c = 0; c < 8; c++) begin
      check_grant($sformatf("hold%0d", c), 1'b1, 3'd0);
      step();
    end
`endif
    req = 8'h01;
    step();
    for (int c = 0; c < 10; c++) begin
      check_grant($sformatf("lone%0d", c), 1'b1, 3'd0);
      step();
    end

    // Asynchronous reset in the middle of a grant.
    req = 8'h20;
    step();
    check_grant("pre_rst", 1'b1, 3'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check_grant("mid_rst", 1'b0, 3'd0);
    req = 8'h04;
    #2;
    rst_n = 1'b1;
    step();
    check_grant("post_rst", 1'b1, 3'd2);
    req = 8'h00;
    step();
    check_grant("final_idle", 1'b0, 3'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
